wb_stage: RTL

Writeback stage of the five-stage pipelined RISC-V core, directly downstream of `mem_stage`. It registers the MEM-stage results in the MEM/WB pipeline register, extracts and sign/zero-extends sub-word load data from the word returned by data memory, and selects the register-file write value. It also provides the retire counter. Its outputs drive the register-file write port and the WB→EX forwarding path.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/load_extend.sv | 53 +++++
 rtl/wb_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: writeback-select codes and load funct3 values.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extraction and sign/zero extension from an aligned memory word.
// Shared with store-to-load forwarding, so it reports raw flags without gating on "is a load".
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // NOTE: every output gets a default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        value      = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      F3_LHU: begin
        value      = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      F3_LW: begin
        value      = word;
        misaligned = (off != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction, register-file write select
// and the instret retire counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [4:0]       rd_mem,
  input  logic             reg_write_mem,
  input  logic             mem_read_mem,
  input  logic [2:0]       funct3_mem,
  input  logic [1:0]       wb_sel_mem,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic [XLEN-1:0]  wb_data,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] instret
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic [2:0]      funct3;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] pc_plus4;
  } mem_wb_t;

  mem_wb_t         r;
  logic [XLEN-1:0] load_value;
  logic            le_misaligned;
  logic            le_illegal;
  logic            illegal_load;
  logic            retire;

  // NOTE: synchronous reset lives inside the clocked block; all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else if (flush) begin
      r <= '0;
    end else if (!stall) begin
      r <= '{valid:      mem_valid,
             rd:         rd_mem,
             reg_write:  reg_write_mem,
             mem_read:   mem_read_mem,
             funct3:     funct3_mem,
             wb_sel:     wb_sel_e'(wb_sel_mem),
             alu_result: alu_result,
             mem_data:   mem_data,
             pc_plus4:   pc_plus4};
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word       (r.mem_data),
    .off        (r.alu_result[1:0]),
    .funct3     (r.funct3),
    .value      (load_value),
    .misaligned (le_misaligned),
    .illegal    (le_illegal)
  );

  assign illegal_load    = r.mem_read & le_illegal;
  assign load_misaligned = r.valid & r.mem_read & le_misaligned;
  assign wb_valid        = r.valid;
  assign wb_rd           = r.rd;
  assign wb_we           = r.valid & r.reg_write & (r.rd != 5'd0) & ~load_misaligned
                         & ~illegal_load & (r.wb_sel != WB_SEL_RSV);

  always_comb begin
    wb_data = '0;
    case (r.wb_sel)
      WB_SEL_ALU: wb_data = r.alu_result;
      WB_SEL_MEM: wb_data = load_value;
      WB_SEL_PC4: wb_data = r.pc_plus4;
      default:    wb_data = '0;
    endcase
  end

  // A stalled instruction retires once, on the edge that releases it or flushes behind it.
  assign retire = r.valid & (~stall | flush) & ~load_misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule
